// File: rtl/mac_sequencer.sv
// MAC instruction-register sequencer: walks {valid, addr, count}, issuing one memory read
// per element and accumulating the signed product of the two returned operands.
module mac_sequencer #(
    parameter int ADDR_W = 21,
    parameter int CNT_W  = 4,
    parameter int STRIDE = 8,
    parameter int DATA_W = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         start_addr,
    input  logic [CNT_W-1:0]          start_count,
    output logic                      busy,
    output logic [ADDR_W+CNT_W:0]     mir,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic                      mem_ack,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [DATA_W-1:0]         acc_out,
    output logic                      done
);

    localparam int HALF = DATA_W / 2;

    // Handshake: mem_req stays high with mem_addr stable until a cycle with mem_ack=1;
    // that cycle transfers mem_rdata. mem_ack may coincide with the first mem_req cycle,
    // and mem_ack in any other state is ignored.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_MAC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic                     valid_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [CNT_W-1:0]         count_q;
    logic [DATA_W-1:0]        operand_q;
    logic [DATA_W-1:0]        acc_q;

    logic [CNT_W-1:0]         count_dec;
    logic [ADDR_W-1:0]        addr_inc;
    logic signed [DATA_W-1:0] op_a;
    logic signed [DATA_W-1:0] op_b;
    logic signed [DATA_W-1:0] product;

    assign count_dec = count_q - CNT_W'(1);
    assign addr_inc  = addr_q + ADDR_W'(STRIDE);
    assign op_a      = {{HALF{operand_q[DATA_W-1]}}, operand_q[DATA_W-1:HALF]};
    assign op_b      = {{HALF{operand_q[HALF-1]}}, operand_q[HALF-1:0]};
    assign product   = op_a * op_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = (start_count != '0) ? S_REQ : S_DONE;
            S_REQ:  if (mem_ack) state_nxt = S_MAC;
            S_MAC:  state_nxt = (count_dec == '0) ? S_DONE : S_REQ;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            addr_q    <= '0;
            count_q   <= '0;
            operand_q <= '0;
            acc_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc_q <= '0;
                        if (start_count != '0) begin
                            valid_q <= 1'b1;
                            addr_q  <= start_addr;
                            count_q <= start_count;
                        end
                    end
                end
                S_REQ: if (mem_ack) operand_q <= mem_rdata;
                S_MAC: begin
                    acc_q <= acc_q + product;
                    // The register is cleared as a whole once the last element retires.
                    if (count_dec == '0) begin
                        valid_q <= 1'b0;
                        addr_q  <= '0;
                        count_q <= '0;
                    end else begin
                        addr_q  <= addr_inc;
                        count_q <= count_dec;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mir      = {valid_q, addr_q, count_q};
    assign mem_addr = addr_q;
    assign mem_req  = (state == S_REQ);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign acc_out  = acc_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: reset, zero-wait run, empty run, wait states,
// address wrap with start-while-busy, and mid-sequence reset.
module tb_mac_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [20:0] start_addr;
    logic [3:0]  start_count;
    logic        busy;
    logic [25:0] mir;
    logic        mem_req;
    logic [20:0] mem_addr;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic [63:0] acc_out;
    logic        done;

    int checks = 0;
    int errors = 0;

    mac_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .start_count(start_count),
        .busy       (busy),
        .mir        (mir),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .acc_out    (acc_out),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input logic [20:0] a, input logic [3:0] c);
        start = 1'b1; start_addr = a; start_count = c;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (10) step();
        checks++; if (mir !== 26'd0) begin errors++; $display("FAIL reset_mir: got %h want 0", mir); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (acc_out !== 64'd0) begin errors++; $display("FAIL reset_acc: got %h want 0", acc_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (mem_addr !== 21'd0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    endtask

    task automatic test_basic_mac();
        logic [63:0] words [3];
        logic [20:0] exp_addr [3];
        logic [25:0] exp_mir [3];
        words[0] = 64'h00000002_00000003;
        words[1] = 64'hFFFFFFFC_00000005;
        words[2] = 64'h00000007_00000001;
        exp_addr[0] = 21'h000100; exp_addr[1] = 21'h000108; exp_addr[2] = 21'h000110;
        exp_mir[0] = {1'b1, 21'h000108, 4'd2};
        exp_mir[1] = {1'b1, 21'h000110, 4'd1};
        exp_mir[2] = 26'd0;
        issue_start(21'h000100, 4'd3);
        checks++; if (mir !== {1'b1, 21'h000100, 4'd3}) begin errors++; $display("FAIL basic_mir_load: got %h want %h", mir, {1'b1, 21'h000100, 4'd3}); end
        for (int e = 0; e < 3; e++) begin
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL basic_req[%0d]: got %b want 1", e, mem_req); end
            checks++; if (mem_addr !== exp_addr[e]) begin errors++; $display("FAIL basic_addr[%0d]: got %h want %h", e, mem_addr, exp_addr[e]); end
            mem_ack = 1'b1; mem_rdata = words[e];
            step();
            mem_ack = 1'b0;
            checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL basic_mac_req[%0d]: got %b want 0", e, mem_req); end
            step();
            checks++; if (mir !== exp_mir[e]) begin errors++; $display("FAIL basic_mir[%0d]: got %h want %h", e, mir, exp_mir[e]); end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", done); end
        checks++; if (acc_out !== 64'hFFFFFFFF_FFFFFFF9) begin errors++; $display("FAIL basic_acc: got %h want fffffffffffffff9", acc_out); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
        checks++; if (acc_out !== 64'hFFFFFFFF_FFFFFFF9) begin errors++; $display("FAIL basic_acc_hold: got %h want fffffffffffffff9", acc_out); end
    endtask

    task automatic test_zero_count();
        issue_start(21'h000abc, 4'd0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL zero_req: got %b want 0", mem_req); end
        checks++; if (acc_out !== 64'd0) begin errors++; $display("FAIL zero_acc: got %h want 0", acc_out); end
        checks++; if (mir !== 26'd0) begin errors++; $display("FAIL zero_mir: got %h want 0", mir); end
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL zero_after: done=%b busy=%b req=%b want 0 0 0", done, busy, mem_req); end
    endtask

    task automatic test_wait_states();
        issue_start(21'h000200, 4'd1);
        for (int i = 0; i < 5; i++) begin
            checks++; if (mem_req !== 1'b1 || mem_addr !== 21'h000200) begin errors++; $display("FAIL wait_hold[%0d]: req=%b addr=%h want 1 000200", i, mem_req, mem_addr); end
            if (i == 4) begin mem_ack = 1'b1; mem_rdata = 64'h00000003_FFFFFFFE; end
            step();
        end
        mem_ack = 1'b0;
        checks++; if (mem_req !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL wait_mac: req=%b done=%b want 0 0", mem_req, done); end
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL wait_done: got %b want 1", done); end
        checks++; if (acc_out !== 64'hFFFFFFFF_FFFFFFFA) begin errors++; $display("FAIL wait_acc: got %h want fffffffffffffffa", acc_out); end
        step();
    endtask

    task automatic test_wrap_busy();
        issue_start(21'h1FFFF8, 4'd2);
        checks++; if (mem_addr !== 21'h1FFFF8) begin errors++; $display("FAIL wrap_addr0: got %h want 1ffff8", mem_addr); end
        mem_ack = 1'b1; mem_rdata = 64'h00000001_00000001;
        step();
        mem_ack = 1'b0;
        start = 1'b1; start_addr = 21'h0ABCDE; start_count = 4'd9;
        step();
        start = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 21'h000000) begin errors++; $display("FAIL wrap_addr1: req=%b addr=%h want 1 000000", mem_req, mem_addr); end
        checks++; if (mir !== {1'b1, 21'h000000, 4'd1}) begin errors++; $display("FAIL wrap_mir: got %h want %h", mir, {1'b1, 21'h000000, 4'd1}); end
        mem_ack = 1'b1; mem_rdata = 64'h00000002_00000002;
        step();
        mem_ack = 1'b0;
        step();
        checks++; if (done !== 1'b1 || acc_out !== 64'd5) begin errors++; $display("FAIL wrap_done: done=%b acc=%h want 1 0000000000000005", done, acc_out); end
        step();
        checks++; if (busy !== 1'b0 || mir !== 26'd0) begin errors++; $display("FAIL wrap_no_queue: busy=%b mir=%h want 0 0", busy, mir); end
    endtask

    task automatic test_mid_reset();
        issue_start(21'h000300, 4'd5);
        mem_ack = 1'b1; mem_rdata = 64'h00000004_00000004;
        step();
        mem_ack = 1'b0;
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 21'h000308) begin errors++; $display("FAIL mid_req2: req=%b addr=%h want 1 000308", mem_req, mem_addr); end
        rst_n = 1'b0;
        #1;
        checks++; if (mir !== 26'd0 || busy !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 21'd0 || acc_out !== 64'd0 || done !== 1'b0) begin
            errors++; $display("FAIL mid_async: mir=%h busy=%b req=%b addr=%h acc=%h done=%b want all 0", mir, busy, mem_req, mem_addr, acc_out, done);
        end
        step();
        rst_n = 1'b1;
        step();
        mem_ack = 1'b1; mem_rdata = 64'h00000009_00000009;
        step();
        mem_ack = 1'b0;
        checks++; if (busy !== 1'b0 || mem_req !== 1'b0 || acc_out !== 64'd0 || mir !== 26'd0) begin errors++; $display("FAIL mid_late_ack: busy=%b req=%b acc=%h mir=%h want 0 0 0 0", busy, mem_req, acc_out, mir); end
        issue_start(21'h000040, 4'd1);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 21'h000040) begin errors++; $display("FAIL mid_restart_req: req=%b addr=%h want 1 000040", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 64'h7FFFFFFF_7FFFFFFF;
        step();
        mem_ack = 1'b0;
        step();
        checks++; if (done !== 1'b1 || acc_out !== 64'h3FFFFFFF_00000001) begin errors++; $display("FAIL mid_restart_acc: done=%b acc=%h want 1 3fffffff00000001", done, acc_out); end
        step();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start_addr = '0; start_count = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        test_reset();
        test_basic_mac();
        test_zero_count();
        test_wait_states();
        test_wrap_busy();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
